fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have the clock input clk and the reset input reset: synchronous, active-high.
REQ-002 The module SHALL have the following ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rom_addr  out  16  instruction memory address (current PC)
- rom_req  out  1  fetch request
- rom_ack  in  1  rom_data valid; completes the request
- rom_data  in  16  instruction word
- instr  out  16  registered instruction to execute stage
- instr_valid  out  1  instr presented
- instr_ready  in  1  execute stage accepts instr
- res_valid  in  1  execute result presented
- res_zr  in  1  ALU out == 0
- res_ng  in  1  ALU out < 0
- res_a  in  16  A register value (jump target)
- retired  out  16  retired-instruction count
- halted  out  1  halt detected; only when FETCH_HALT_EN is defined

Function
REQ-003 The sequencer SHALL have four states: FETCH, ISSUE, EXEC and HALT.
REQ-004 In FETCH, rom_req=1 and rom_addr=pc; on rom_ack=1, the sequencer SHALL latch instr=rom_data, set instr_valid=1, drop rom_req, and go to ISSUE at the next edge.
REQ-005 In ISSUE, instr_valid SHALL hold and instr SHALL stay stable until instr_ready=1; on that edge, instr_valid drops and the state goes to EXEC.
REQ-006 In EXEC, the sequencer SHALL wait for res_valid=1, then update pc on that edge and return to FETCH; the next rom_req occurs in the following cycle.
REQ-007 The jump decision SHALL be taken only when instr[15]=1, as (instr[2]&ng) | (instr[1]&zr) | (instr[0]&~zr&~ng); if taken, pc=res_a, else pc=pc+1.
REQ-008 An A-instruction (instr[15]=0) SHALL always give pc=pc+1, regardless of the flags.
REQ-009 pc+1 SHALL be a 16-bit modulo increment: 0xFFFF becomes 0x0000, with no flag.
REQ-010 retired SHALL increment by 1 on each res_valid edge in EXEC, and SHALL saturate at 0xFFFF.
REQ-011 rom_ack outside FETCH, instr_ready outside ISSUE, and res_valid outside EXEC SHALL be ignored with no state change.
REQ-012 rom_ack and rom_data SHALL be sampled only while rom_req=1; ROM latency is unbounded (zero-wait ack allowed on the first request cycle).
REQ-013 Minimum instruction cycle SHALL be 3 clocks: ack in the 1st FETCH cycle, ready in the 1st ISSUE cycle, and res_valid in the 1st EXEC cycle.

Reset
REQ-014 With reset=1 at an edge, the block SHALL set state=FETCH, pc=0, rom_req=1 (in the following cycle), instr=0, instr_valid=0, retired=0 and halted=0.
REQ-015 Reset SHALL dominate all other inputs in any state, including mid-fetch with ack pending and mid-ISSUE; any in-flight instruction is discarded and not counted.
REQ-016 After reset deasserts, the first fetch SHALL be from address 0x0000.

Configuration
REQ-017 The macro FETCH_HALT_EN SHALL enable halt detection.
REQ-018 With FETCH_HALT_EN defined: when a taken jump has res_a equal to the current pc, the block SHALL enter HALT and set halted=1.
- In HALT: rom_req=0 and instr_valid=0; retired counts the halting instruction.
- The block stays in HALT until reset.
REQ-019 Without FETCH_HALT_EN: the halted port and the HALT state SHALL be absent; a self-jump simply refetches the same address forever.

Verification
REQ-020 Reset, then ack immediately with 0x0005 -> rom_addr=0x0000, instr=0x0005 valid the next cycle; ready+res_valid -> next rom_addr=0x0001, retired=1.
REQ-021 C-instr 0xE302 (D;JEQ), res_zr=1, res_a=0x0100 -> next rom_addr=0x0100; repeat with res_zr=0, res_ng=0 -> rom_addr=pc+1.
REQ-022 Drive pc to 0xFFFF via jump, then execute A-instr 0x0010 -> next rom_addr=0x0000.
REQ-023 ROM ack delayed 5 cycles and instr_ready delayed 3 cycles -> rom_req held for 5 cycles, then instr stable with instr_valid=1 for 3 cycles; stray res_valid during ISSUE is ignored.
REQ-024 Assert reset during ISSUE -> instr_valid=0 and rom_addr=0x0000 next cycle; retired=0.
REQ-025 FETCH_HALT_EN: at pc=0x0004, 0;JMP (0xEA87) with res_a=0x0004 -> halted=1, rom_req=0 permanently, retired incremented once; without the macro -> repeated fetches of 0x0004.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch/issue/execute instruction sequencer with PC, jump logic
//               and a saturating retired-instruction counter.
//               Optional halt detection on self-jump via FETCH_HALT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] rom_addr,
   output logic        rom_req,
   input  logic        rom_ack,
   input  logic [15:0] rom_data,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        res_valid,
   input  logic        res_zr,
   input  logic        res_ng,
   input  logic [15:0] res_a,
   output logic [15:0] retired
`ifdef FETCH_HALT_EN
   ,
   output logic        halted
`endif
);

   localparam logic [1:0] c_FETCH = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_EXEC  = 2'd2;
`ifdef FETCH_HALT_EN
   localparam logic [1:0] c_HALT  = 2'd3;
`endif

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] retired_q, retired_d;
   logic        w_jump;
   logic        w_fire;

   // A-instructions (bit 15 clear) never jump.
   assign w_jump = instr_q[15] & ((instr_q[2] & res_ng) |
                                  (instr_q[1] & res_zr) |
                                  (instr_q[0] & ~res_zr & ~res_ng));
   assign w_fire = (state_q == c_EXEC) && res_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= c_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_FETCH: if (rom_ack)     state_d = c_ISSUE;
         c_ISSUE: if (instr_ready) state_d = c_EXEC;
         c_EXEC: begin
            if (res_valid) begin
`ifdef FETCH_HALT_EN
               state_d = (w_jump && (res_a == pc_q)) ? c_HALT : c_FETCH;
`else
               state_d = c_FETCH;
`endif
            end
         end
`ifdef FETCH_HALT_EN
         c_HALT:  state_d = c_HALT;
`endif
         default: state_d = c_FETCH;
      endcase
   end

   always_comb begin
      rom_req     = (state_q == c_FETCH);
      instr_valid = (state_q == c_ISSUE);
`ifdef FETCH_HALT_EN
      halted      = (state_q == c_HALT);
`endif
   end

   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      if ((state_q == c_FETCH) && rom_ack) begin
         instr_d = rom_data;
      end
      if (w_fire) begin
         pc_d      = w_jump ? res_a : pc_q + 16'd1;
         retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= 16'h0000;
         instr_q   <= 16'h0000;
         retired_q <= 16'h0000;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   assign rom_addr = pc_q;
   assign instr    = instr_q;
   assign retired  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Randomized self-checking bench for fetch_sequencer against a
//               transaction-level reference model. Honours FETCH_HALT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic [15:0] rom_addr;
   logic        rom_req;
   logic        rom_ack;
   logic [15:0] rom_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        res_valid;
   logic        res_zr;
   logic        res_ng;
   logic [15:0] res_a;
   logic [15:0] retired;
`ifdef FETCH_HALT_EN
   logic        halted;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_retired;
   logic [15:0] m_instr;
   logic        m_fresh;
   logic        m_halted;

   fetch_sequencer u_dut (
      .clk         (clk),
      .reset       (reset),
      .rom_addr    (rom_addr),
      .rom_req     (rom_req),
      .rom_ack     (rom_ack),
      .rom_data    (rom_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .res_valid   (res_valid),
      .res_zr      (res_zr),
      .res_ng      (res_ng),
      .res_a       (res_a),
      .retired     (retired)
`ifdef FETCH_HALT_EN
      ,
      .halted      (halted)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic exp_outs(input logic req, input logic iv);
      chk_eq("rom_req", {31'd0, rom_req}, {31'd0, req});
      chk_eq("instr_valid", {31'd0, instr_valid}, {31'd0, iv});
      if (req) chk_eq("rom_addr", {16'd0, rom_addr}, {16'd0, m_pc});
      if (iv || m_fresh) chk_eq("instr", {16'd0, instr}, {16'd0, m_instr});
      chk_eq("retired", {16'd0, retired}, {16'd0, m_retired});
`ifdef FETCH_HALT_EN
      chk_eq("halted", {31'd0, halted}, {31'd0, m_halted});
`endif
   endtask

   task automatic drive_rand();
      reset       = 1'b0;
      rom_ack     = 1'($urandom);
      rom_data    = 16'($urandom);
      instr_ready = 1'($urandom);
      res_valid   = 1'($urandom);
      res_zr      = 1'($urandom);
      res_ng      = 1'($urandom);
      res_a       = 16'($urandom);
   endtask

   task automatic model_reset();
      m_pc      = 16'h0000;
      m_retired = 16'h0000;
      m_instr   = 16'h0000;
      m_fresh   = 1'b1;
      m_halted  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_rand();
      reset = 1'b1;
      @(posedge clk);
      model_reset();
   endtask

   // abort: 0 = complete, 1 = reset on the ack edge, 2 = reset during issue
   task automatic do_instr(input logic [15:0] word, input logic [15:0] a,
                           input logic zr, input logic ng,
                           input int ack_dly, input int rdy_dly, input int res_dly,
                           input int abort);
      logic taken;
      for (int i = 0; i <= ack_dly; i++) begin
         @(negedge clk);
         exp_outs(1'b1, 1'b0);
         drive_rand();
         rom_ack = (i == ack_dly);
         if (i == ack_dly) rom_data = word;
         reset = (abort == 1) && (i == ack_dly);
         @(posedge clk);
      end
      if (abort == 1) begin
         model_reset();
         return;
      end
      m_instr = word;
      m_fresh = 1'b0;
      for (int i = 0; i <= rdy_dly; i++) begin
         @(negedge clk);
         exp_outs(1'b0, 1'b1);
         drive_rand();
         instr_ready = (i == rdy_dly);
         reset = (abort == 2) && (i == rdy_dly);
         @(posedge clk);
      end
      if (abort == 2) begin
         model_reset();
         return;
      end
      for (int i = 0; i <= res_dly; i++) begin
         @(negedge clk);
         exp_outs(1'b0, 1'b0);
         drive_rand();
         res_valid = (i == res_dly);
         if (i == res_dly) begin
            res_zr = zr;
            res_ng = ng;
            res_a  = a;
         end
         @(posedge clk);
      end
      taken = word[15] && ((word[2] && ng) || (word[1] && zr) || (word[0] && !zr && !ng));
      if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
`ifdef FETCH_HALT_EN
      if (taken && (a == m_pc)) m_halted = 1'b1;
`endif
      m_pc = taken ? a : m_pc + 16'd1;
   endtask

   initial begin
      logic [15:0] w;
      logic [15:0] a;
      int          ab;

      drive_rand();
      do_reset();
      do_reset();

      // First fetch from 0, zero-wait everywhere
      do_instr(16'h0005, 16'h1234, 1'b0, 1'b0, 0, 0, 0, 0);
      // D;JEQ taken, then not taken
      do_instr(16'hE302, 16'h0100, 1'b1, 1'b0, 0, 0, 0, 0);
      do_instr(16'hE302, 16'h0200, 1'b0, 1'b0, 0, 0, 0, 0);
      // Unconditional jump to 0xFFFF, then A-instr wraps to 0
      do_instr(16'hE307, 16'hFFFF, 1'b0, 1'b1, 0, 0, 0, 0);
      do_instr(16'h0010, 16'h4444, 1'b1, 1'b1, 0, 0, 0, 0);
      // Slow ROM and slow execute stage
      do_instr(16'hFC10, 16'h0777, 1'b0, 1'b0, 5, 3, 2, 0);
      // Reset mid-issue, then mid-fetch on the ack edge
      do_instr(16'h0003, 16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);
      do_instr(16'h0042, 16'h0000, 1'b0, 1'b0, 1, 2, 0, 2);
      do_instr(16'h0042, 16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);
      do_instr(16'hE307, 16'h0ABC, 1'b0, 1'b0, 2, 0, 0, 1);
      do_instr(16'h0042, 16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);

      // Self-jump at pc 4
      do_reset();
      for (int i = 0; i < 4; i++) do_instr(16'h0001, 16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);
      do_instr(16'hEA87, 16'h0004, 1'b0, 1'b0, 0, 0, 0, 0);
`ifdef FETCH_HALT_EN
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_outs(1'b0, 1'b0);
         drive_rand();
         @(posedge clk);
      end
`else
      for (int i = 0; i < 3; i++) do_instr(16'hEA87, 16'h0004, 1'b0, 1'b0, 0, 0, 0, 0);
`endif
      do_reset();

      for (int n = 0; n < 200; n++) begin
         w = 16'($urandom);
         if ($urandom_range(1, 0) == 1) w[15] = 1'b1;
         a = 16'($urandom);
         if (a == m_pc) a = a + 16'd1;
         ab = ($urandom_range(19, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
         do_instr(w, a, 1'($urandom), 1'($urandom),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)), ab);
      end

      @(negedge clk);
      exp_outs(1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
